// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit_if
// Description : Bundle of pipeline-side signals exchanged with the forwarding
//               and hazard unit.
//               master - pipeline control (drives ID/EXE info, freeze, flush)
//               slave  - fwd_hazard_unit (returns operand selects and stall)
// Ports       : freeze, flush          pipeline control
//               id_*                   instruction currently in ID
//               exe_*                  source operands of instruction in EXE
//               sel_src1, sel_src2     forwarding selects (0 = register file)
//               stall                  load-use / dependency stall
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_hazard_unit_if #(
    parameter int REG_W = 4,
    parameter int SEL_W = 2
);
    logic             freeze;
    logic             flush;
    logic             id_valid;
    logic             id_wb_en;
    logic             id_mem_r;
    logic [REG_W-1:0] id_dest;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_use1;
    logic             id_use2;
    logic [REG_W-1:0] exe_src1;
    logic [REG_W-1:0] exe_src2;
    logic             exe_use1;
    logic             exe_use2;
    logic [SEL_W-1:0] sel_src1;
    logic [SEL_W-1:0] sel_src2;
    logic             stall;

    modport master (
        output freeze, flush,
        output id_valid, id_wb_en, id_mem_r, id_dest,
        output id_src1, id_src2, id_use1, id_use2,
        output exe_src1, exe_src2, exe_use1, exe_use2,
        input  sel_src1, sel_src2, stall
    );

    modport slave (
        input  freeze, flush,
        input  id_valid, id_wb_en, id_mem_r, id_dest,
        input  id_src1, id_src2, id_use1, id_use2,
        input  exe_src1, exe_src2, exe_use1, exe_use2,
        output sel_src1, sel_src2, stall
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Forwarding and hazard unit for the pipelined ARM core. Keeps a
//               private shift pipe of destination tags T[0..NUM_FWD]
//               (T[0] = EXE, T[NUM_FWD] = WB) loaded at the ID/EXE boundary,
//               derives per-operand forwarding selects for EXE (nearest stage
//               wins) and a load-use stall toward IF/ID.
// Config      : FWD_UNIT_FORWARD_EN defined   -> forwarding + load-use stall
//               FWD_UNIT_FORWARD_EN undefined -> no-forwarding debug build:
//                   selects tied to 0, stall on any dependency in T[0..NUM_FWD-1]
// Ports       : clk, rst            clock, synchronous active-high reset
//               bus (slave)         freeze/flush, ID and EXE operand info,
//                                   sel_src1/sel_src2/stall outputs
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_W      = 4,
    parameter int NUM_FWD    = 2,
    parameter int SEL_W      = 2,
    parameter int LOAD_STAGE = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fwd_hazard_unit_if.slave  bus
);

    // Tag pipe: one entry per stage from EXE to WB.
    logic [NUM_FWD:0] r_valid;
    logic [NUM_FWD:0] r_wb_en;
    logic [NUM_FWD:0] r_is_load;
    logic [REG_W-1:0] r_dest [0:NUM_FWD];

    logic             w_stall;
    logic [SEL_W-1:0] w_sel1;
    logic [SEL_W-1:0] w_sel2;
    logic             w_hit1;
    logic             w_hit2;

    // ------------------------------------------------------------------
    // Tag pipe update: rst > freeze > (flush | stall -> bubble) > normal
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_wb_en   <= '0;
            r_is_load <= '0;
            for (int k = 0; k <= NUM_FWD; k++) begin
                r_dest[k] <= '0;
            end
        end else if (!bus.freeze) begin
            for (int k = NUM_FWD; k >= 1; k--) begin
                r_valid[k]   <= r_valid[k-1];
                r_wb_en[k]   <= r_wb_en[k-1];
                r_is_load[k] <= r_is_load[k-1];
                r_dest[k]    <= r_dest[k-1];
            end
            // A squashed or stalled ID instruction enters EXE as a bubble;
            // only the valid bit matters, the other fields are don't-care.
            r_valid[0]   <= bus.id_valid & ~(bus.flush | w_stall);
            r_wb_en[0]   <= bus.id_wb_en;
            r_is_load[0] <= bus.id_mem_r;
            r_dest[0]    <= bus.id_dest;
        end
    end

`ifdef FWD_UNIT_FORWARD_EN
    // ------------------------------------------------------------------
    // Forwarding selects: scan oldest to nearest so the nearest match is
    // the last one written. Loads younger than LOAD_STAGE have no data yet
    // and are skipped; the stall keeps such a consumer out of EXE anyway.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        for (int k = NUM_FWD; k >= 1; k--) begin
            if (bus.exe_use1 && r_valid[k] && r_wb_en[k] &&
                (r_dest[k] == bus.exe_src1) &&
                !(r_is_load[k] && (k < LOAD_STAGE))) begin
                w_sel1 = SEL_W'(k);
            end
            if (bus.exe_use2 && r_valid[k] && r_wb_en[k] &&
                (r_dest[k] == bus.exe_src2) &&
                !(r_is_load[k] && (k < LOAD_STAGE))) begin
                w_sel2 = SEL_W'(k);
            end
        end
    end

    // Load-use: a load that will not yet have data when the ID consumer
    // reaches EXE. Both operands hitting one load still yield one stall.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int k = 0; k < LOAD_STAGE - 1; k++) begin
            if (r_valid[k] && r_wb_en[k] && r_is_load[k] &&
                (r_dest[k] == bus.id_src1)) begin
                w_hit1 = 1'b1;
            end
            if (r_valid[k] && r_wb_en[k] && r_is_load[k] &&
                (r_dest[k] == bus.id_src2)) begin
                w_hit2 = 1'b1;
            end
        end
    end
`else
    // No forwarding: every producer still in flight blocks the consumer.
    // WB is excluded because the register file writes through to reads.
    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (r_valid[k] && r_wb_en[k] && (r_dest[k] == bus.id_src1)) begin
                w_hit1 = 1'b1;
            end
            if (r_valid[k] && r_wb_en[k] && (r_dest[k] == bus.id_src2)) begin
                w_hit2 = 1'b1;
            end
        end
    end

    // Inputs and tag fields with no consumer in this build.
    localparam logic c_LOAD_STAGE_OK = (LOAD_STAGE >= 1);
    logic w_unused;
    assign w_unused = ^{bus.exe_src1, bus.exe_src2, bus.exe_use1, bus.exe_use2,
                        r_is_load, r_valid[NUM_FWD], r_wb_en[NUM_FWD],
                        r_dest[NUM_FWD], c_LOAD_STAGE_OK};
`endif

    // Flush squashes the ID instruction, so its hazard is irrelevant.
    assign w_stall = ~bus.flush & ((bus.id_use1 & w_hit1) | (bus.id_use2 & w_hit2));

    // Outputs are held quiet while reset is asserted.
    assign bus.sel_src1 = rst ? '0   : w_sel1;
    assign bus.sel_src2 = rst ? '0   : w_sel2;
    assign bus.stall    = rst ? 1'b0 : w_stall;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Scoreboard bench for fwd_hazard_unit. A small instruction
//               pipeline driver issues directed and random instructions; a
//               queue-based reference model predicts sel_src1/sel_src2/stall
//               each cycle and a negedge monitor compares against the DUT.
//               Honours FWD_UNIT_FORWARD_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int REG_W      = 4;
    localparam int NUM_FWD    = 2;
    localparam int SEL_W      = 2;
    localparam int LOAD_STAGE = 2;

    logic clk = 1'b0;
    logic rst;

    fwd_hazard_unit_if #(.REG_W(REG_W), .SEL_W(SEL_W)) bus ();

    fwd_hazard_unit #(
        .REG_W      (REG_W),
        .NUM_FWD    (NUM_FWD),
        .SEL_W      (SEL_W),
        .LOAD_STAGE (LOAD_STAGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        bit wb;
        bit ld;
        int dest;
        int s1;
        bit u1;
        int s2;
        bit u2;
    } ins_t;

    typedef struct {
        bit valid;
        bit wb_en;
        bit is_load;
        int dest;
    } tag_t;

    typedef struct {
        int sel1;
        int sel2;
        bit stall;
    } exp_t;

    tag_t  tags[$];      // tags[0] = EXE ... tags[NUM_FWD] = WB
    exp_t  exp_q[$];
    ins_t  id_ins;
    ins_t  exe_ins;
    ins_t  nop;
    bit    rand_exe;
    bit    last_stall;
    int    checks = 0;
    int    errors = 0;

    // ---------------- reference model ----------------
    function automatic bit writes(tag_t t, int r);
        return t.valid && t.wb_en && (t.dest == r);
    endfunction

    function automatic int fwd_sel(int r, bit used);
        if (!used) return 0;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (writes(tags[k], r) && !(tags[k].is_load && k < LOAD_STAGE))
                return k;
        end
        return 0;
    endfunction

    function automatic bit blocked(int r, bit used);
        if (!used) return 0;
`ifdef FWD_UNIT_FORWARD_EN
        for (int k = 0; k <= LOAD_STAGE - 2; k++)
            if (writes(tags[k], r) && tags[k].is_load) return 1;
`else
        for (int k = 0; k < NUM_FWD; k++)
            if (writes(tags[k], r)) return 1;
`endif
        return 0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.sel1  = 0;
        e.sel2  = 0;
        e.stall = 0;
        if (!rst) begin
`ifdef FWD_UNIT_FORWARD_EN
            e.sel1 = fwd_sel(int'(bus.exe_src1), bus.exe_use1);
            e.sel2 = fwd_sel(int'(bus.exe_src2), bus.exe_use2);
`endif
            e.stall = !bus.flush && (blocked(int'(bus.id_src1), bus.id_use1) ||
                                     blocked(int'(bus.id_src2), bus.id_use2));
        end
        return e;
    endfunction

    task automatic model_clock(bit stall_now);
        tag_t t;
        if (rst) begin
            foreach (tags[k]) tags[k].valid = 0;
        end else if (!bus.freeze) begin
            t.valid   = bus.id_valid && !bus.flush && !stall_now;
            t.wb_en   = bus.id_wb_en;
            t.is_load = bus.id_mem_r;
            t.dest    = int'(bus.id_dest);
            tags.push_front(t);
            void'(tags.pop_back());
        end
    endtask

    // ---------------- stimulus ----------------
    function automatic ins_t mk(bit ld, int dest, int s1, bit u1, int s2, bit u2);
        ins_t i;
        i.valid = 1; i.wb = 1; i.ld = ld; i.dest = dest;
        i.s1 = s1; i.u1 = u1; i.s2 = s2; i.u2 = u2;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.valid = ($urandom_range(0, 7) != 0);
        i.wb    = ($urandom_range(0, 5) != 0);
        i.ld    = ($urandom_range(0, 2) == 0);
        i.dest  = $urandom_range(0, 3);
        i.s1    = $urandom_range(0, 3);
        i.u1    = $urandom_range(0, 1);
        i.s2    = $urandom_range(0, 3);
        i.u2    = $urandom_range(0, 1);
        return i;
    endfunction

    task automatic apply();
        bus.id_valid = id_ins.valid;
        bus.id_wb_en = id_ins.wb;
        bus.id_mem_r = id_ins.ld;
        bus.id_dest  = REG_W'(id_ins.dest);
        bus.id_src1  = REG_W'(id_ins.s1);
        bus.id_use1  = id_ins.u1;
        bus.id_src2  = REG_W'(id_ins.s2);
        bus.id_use2  = id_ins.u2;
        if (rand_exe) begin
            bus.exe_src1 = REG_W'($urandom_range(0, 3));
            bus.exe_use1 = 1'($urandom_range(0, 1));
            bus.exe_src2 = REG_W'($urandom_range(0, 3));
            bus.exe_use2 = 1'($urandom_range(0, 1));
        end else begin
            bus.exe_src1 = REG_W'(exe_ins.s1);
            bus.exe_use1 = exe_ins.valid && exe_ins.u1;
            bus.exe_src2 = REG_W'(exe_ins.s2);
            bus.exe_use2 = exe_ins.valid && exe_ins.u2;
        end
    endtask

    // One clock: predict, queue expectation, advance model and driver pipe.
    task automatic step();
        exp_t e;
        apply();
        e = predict();
        exp_q.push_back(e);
        last_stall = e.stall;
        @(posedge clk);
        model_clock(e.stall);
        if (rst) exe_ins = nop;
        else if (!bus.freeze) exe_ins = (bus.flush || e.stall) ? nop : id_ins;
        #1;
    endtask

    // Present an instruction in ID and hold it there while it is stalled.
    task automatic issue(ins_t i);
        int n;
        id_ins = i;
        step();
        n = 0;
        while (last_stall && n < 16) begin
            step();
            n++;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.sel_src1 !== SEL_W'(e.sel1)) begin
                errors++;
                $display("FAIL sel_src1 t=%0t actual %0d required %0d", $time, bus.sel_src1, e.sel1);
            end
            checks++;
            if (bus.sel_src2 !== SEL_W'(e.sel2)) begin
                errors++;
                $display("FAIL sel_src2 t=%0t actual %0d required %0d", $time, bus.sel_src2, e.sel2);
            end
            checks++;
            if (bus.stall !== e.stall) begin
                errors++;
                $display("FAIL stall t=%0t actual %0b required %0b", $time, bus.stall, e.stall);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        nop = '{valid: 0, wb: 0, ld: 0, dest: 0, s1: 0, u1: 0, s2: 0, u2: 0};
        exe_ins  = nop;
        rand_exe = 0;
        for (int k = 0; k <= NUM_FWD; k++) tags.push_back('{valid: 0, wb_en: 0, is_load: 0, dest: 0});

        rst = 1'b1;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        id_ins = rnd_ins();
        apply();
        @(posedge clk);
        #1;

        // Reset for two cycles with random inputs.
        rand_exe = 1;
        id_ins = rnd_ins(); step();
        id_ins = rnd_ins(); step();
        rand_exe = 0;
        rst = 1'b0;

        // Back-to-back dependency, then a one-instruction gap.
        issue(mk(0, 3, 1, 1, 2, 1));   // ADD r3, r1, r2
        issue(mk(0, 6, 3, 1, 7, 1));   // SUB r6, r3, r7
        issue(nop);
        issue(mk(0, 3, 1, 1, 2, 1));   // ADD r3
        issue(nop);
        issue(mk(0, 6, 3, 1, 7, 1));   // SUB r6, r3
        issue(nop);
        issue(nop);

        // r5 written twice, read on src2: nearest wins.
        issue(mk(0, 5, 1, 1, 1, 0));
        issue(mk(0, 5, 2, 1, 2, 0));
        issue(mk(0, 8, 9, 0, 5, 1));
        issue(nop);
        issue(nop);

        // Load-use.
        issue(mk(1, 2, 0, 1, 0, 0));   // LDR r2
        issue(mk(0, 9, 2, 1, 2, 1));   // ADD r9, r2, r2
        issue(nop);
        issue(nop);

        // Load-use with a 3-cycle freeze inside the stall.
        issue(mk(1, 2, 0, 1, 0, 0));
        id_ins = mk(0, 9, 2, 1, 4, 1);
        step();
        bus.freeze = 1'b1;
        repeat (3) step();
        bus.freeze = 1'b0;
        issue(id_ins);
        issue(nop);
        issue(nop);

        // Load-use hazard coinciding with a flush.
        issue(mk(1, 2, 0, 1, 0, 0));
        id_ins = mk(0, 2, 2, 1, 0, 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        issue(mk(0, 7, 2, 1, 2, 1));
        issue(nop);
        issue(nop);

        // Reset in the middle of a stall.
        issue(mk(1, 1, 0, 0, 0, 0));
        id_ins = mk(0, 4, 1, 1, 1, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue(nop);

        // Random phase.
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 63) == 0);
            bus.freeze = ($urandom_range(0, 7) == 0);
            bus.flush  = ($urandom_range(0, 9) == 0);
            rand_exe   = ($urandom_range(0, 3) == 0);
            if (!last_stall || $urandom_range(0, 3) == 0) id_ins = rnd_ins();
            step();
        end
        rst = 1'b0; bus.freeze = 1'b0; bus.flush = 1'b0; rand_exe = 0;

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d pending required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined ARM core.
- Keeps its own shift pipeline of destination tags covering EXE..WB, loaded from the ID/EXE boundary. Hazard tracking no longer depends on the pipeline registers.
- Produces per-operand forwarding selects for EXE, with nearest stage winning.
- Produces a load-use stall toward the hazard/IF/ID logic, and handles freeze and flush.

Parameters:
- REG_W, 4, register address width.
- NUM_FWD, 2, number of forwarding source stages after EXE (1 = MEM, 2 = WB, ...). Tag pipe has NUM_FWD+1 entries.
- SEL_W, 2, select width. Must satisfy 2**SEL_W > NUM_FWD.
- LOAD_STAGE, 2, first tag index at which load data can be forwarded. Range 1..NUM_FWD.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- freeze  in  1  memory-stall freeze; tag pipe holds.
- flush  in  1  branch taken; instruction now in ID is squashed.
- id_valid  in  1  ID stage holds a real instruction.
- id_wb_en  in  1  ID instruction writes a register.
- id_mem_r  in  1  ID instruction is a load.
- id_dest  in  REG_W  ID destination.
- id_src1, id_src2  in  REG_W  ID source registers.
- id_use1, id_use2  in  1  ID source actually read.
- exe_src1, exe_src2  in  REG_W  sources of the instruction in EXE.
- exe_use1, exe_use2  in  1  EXE source actually read.
- sel_src1, sel_src2  out  SEL_W  0 = register file, k = forward from tag stage k.
- stall  out  1  hold PC and IF/ID; insert bubble into EXE.

Behaviour:
- Tag entry T[k], k = 0..NUM_FWD, holds {valid, wb_en, is_load, dest}. T[0] = EXE, T[NUM_FWD] = WB.
- Reset: every T[k].valid = 0. sel_src1 = sel_src2 = 0 and stall = 0 in the cycle after reset and while rst is high.
- Update priority on each rising edge is rst > freeze > flush/stall > normal:
  - freeze = 1: all T[k] hold.
  - Otherwise T[k] <= T[k-1] for k >= 1, and T[0] loads as follows:
    - bubble (valid = 0) if flush or stall;
    - otherwise {id_valid, id_wb_en, id_mem_r, id_dest}.
- Match definition: T[k] matches r when valid & wb_en & dest == r.
- sel_srcN: smallest k in 1..NUM_FWD with T[k] matching exe_srcN and exe_useN = 1; else 0.
  - Combinational from the registered tags.
  - Latency 0 relative to tag state.
  - Nearest stage always wins over older stages.
- A load in T[k] with k < LOAD_STAGE is never selected. Search continues to older stages; the stall logic guarantees this case does not reach EXE.
- stall = !flush & (id_use1 & m(id_src1) | id_use2 & m(id_src2)).
  - m(r) = some T[k] with k <= LOAD_STAGE-2 matches r and is_load = 1.
  - With the defaults, this is a load in EXE.
  - Stall lasts exactly until the load reaches T[LOAD_STAGE-1]. Default is 1 cycle, extended by any freeze cycles.
- Back-to-back loads, or both sources hitting the same load, give one stall, not two.
- Register 15 is not special-cased; the PC path is handled upstream.
- Reset mid-stall: stall drops in the cycle after reset; no pending hazard survives.
- flush and stall together: flush wins; stall = 0 and a bubble is inserted.

Optional Feature:
- Macro: FWD_UNIT_FORWARD_EN.
- Defined: forwarding and load-use stall behave as above.
- Undefined (no-forwarding debug build):
  - sel_src1 and sel_src2 are tied to 0.
  - stall = !flush & any used ID source matching any T[k] with k in 0..NUM_FWD-1, load or not.
  - T[NUM_FWD] is excluded because the register file is write-through.

Test Plan:
- Reset with rst = 1 for 2 cycles, random inputs -> stall = 0, sel = 0; the first instruction after reset sees no matches.
- ADD r3, then SUB using r3 as src1 in the next cycle -> sel_src1 = 1 (MEM), sel_src2 = 0, stall = 0. With a one-instruction gap -> sel_src1 = 2.
- Writes to r5 in MEM and WB both, EXE reads r5 on src2 -> sel_src2 = 1 (nearest wins).
- LDR r2, then ADD reading r2 -> stall = 1 for 1 cycle, T[0] bubble, then sel = 2 when the ADD is in EXE. Same with freeze = 1 for 3 cycles during the stall -> stall stays high, tags unchanged.
- Load-use hazard with flush = 1 in the same cycle -> stall = 0, bubble inserted, no later forward from the squashed instruction.
- Build without FWD_UNIT_FORWARD_EN, ADD r4 then use r4 -> sel = 0, stall = 1 for NUM_FWD cycles (2 by default).
